gpio_scan_master: RTL and testbench
===================================

GPIO_SCAN_MASTER -- requirements
Module: gpio_scan_master

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 8, SRAM address bits; DATA_WIDTH, 8, SRAM data bits; CLK_DIV, 2, clk cycles per gpio_clk half-period (legal range >=1); LOAD_CYCLES, 1, gpio_clk cycles with gpio_sram_load high.
REQ-002 PKT_WIDTH SHALL equal ADDR_WIDTH+DATA_WIDTH+2.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  block idle, command accepted when both high
  cmd_csb  in  1  packet chip-select (0 = active)
  cmd_web  in  1  packet write-enable (0 = write, 1 = read)
  cmd_addr  in  ADDR_WIDTH  SRAM address
  cmd_wdata  in  DATA_WIDTH  write data
  cmd_expect  in  DATA_WIDTH  expected read data
  rsp_valid  out  1  result available
  rsp_ready  in  1  result consumed when both high
  rsp_rdata  out  DATA_WIDTH  data scanned out
  rsp_mismatch  out  1  rsp_rdata != captured cmd_expect (read only)
  gpio_clk  out  1  scan clock to chip
  gpio_scan  out  1  scan-shift enable
  gpio_in  out  1  serial scan data to chip
  gpio_sram_load  out  1  load/execute strobe
  global_csb  out  1  chip global select, low while busy
  gpio_out  in  1  serial scan data from chip

Function
REQ-005 Packet SHALL be {cmd_csb, cmd_web, cmd_addr, cmd_wdata}, shifted MSB first.
REQ-006 All cmd_* fields SHALL be captured on the accepting cycle; later changes ignored.
REQ-007 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored.
REQ-008 States: IDLE, SHIFT_IN, LOAD, SHIFT_OUT, RESP.
REQ-009 Scan cycle = 2*CLK_DIV clk: gpio_clk low for the first CLK_DIV clk, high for the next CLK_DIV clk; gpio_clk rising edge lies between them.
REQ-010 gpio_in, gpio_scan and gpio_sram_load SHALL change only on the first clk of a low phase.
REQ-011 gpio_clk SHALL be held 0 in IDLE and RESP; first low phase starts on the clk after acceptance.
REQ-012 SHIFT_IN: gpio_scan=1, gpio_sram_load=0, one packet bit per scan cycle, exactly PKT_WIDTH scan cycles.
REQ-013 LOAD: gpio_scan=0, gpio_in=0, gpio_sram_load=1 for exactly LOAD_CYCLES scan cycles.
REQ-014 After LOAD: if captured web=1, go to SHIFT_OUT; if web=0, go to RESP.
REQ-015 SHIFT_OUT: gpio_scan=1, gpio_sram_load=0, gpio_in=0, exactly DATA_WIDTH scan cycles.
REQ-016 In SHIFT_OUT, gpio_out SHALL be sampled on the last clk of each low phase, MSB first, into rsp_rdata.
REQ-017 RESP: rsp_valid=1 from the clk after the final scan cycle ends; held with stable data until rsp_valid and rsp_ready, then return to IDLE next clk.
REQ-018 Write result: rsp_rdata=0, rsp_mismatch=0.
REQ-019 Read result: rsp_mismatch = (rsp_rdata != captured expect).
REQ-020 global_csb SHALL be 0 in SHIFT_IN, LOAD and SHIFT_OUT, and 1 otherwise.
REQ-021 Latency from accept to rsp_valid: write = (PKT_WIDTH+LOAD_CYCLES)*2*CLK_DIV+1 clk; read adds DATA_WIDTH*2*CLK_DIV.
REQ-022 Divider and bit counters SHALL be sized for the maximum parameter values with no wrap inside a phase; a bit counter reaching its terminal count SHALL advance state on the same edge.

Reset
REQ-023 Reset SHALL take effect on the next clk edge from any state, including mid-shift; it aborts the operation with no response.
REQ-024 Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_mismatch=0, gpio_clk=0, gpio_scan=0, gpio_in=0, gpio_sram_load=0, global_csb=1.

Verification (defaults; PKT_WIDTH=18, scan cycle=4 clk)
REQ-025 Write csb=0, web=0, addr=0x5A, wdata=0xC3 -> gpio_in on 18 rising edges = 00_01011010_11000011; one load pulse; rsp_valid exactly 77 clk after accept; rdata=0, mismatch=0.
REQ-026 Read web=1, addr=0x5A, expect=0xC3, chip model returns 0xC3 -> 8 samples; rsp_valid at clk 109; rdata=0xC3, mismatch=0.
REQ-027 Same read with model returning 0xC2 -> rdata=0xC2, mismatch=1.
REQ-028 rsp_ready held low for 10 clk -> rsp_valid and data stable, cmd_ready=0; second cmd_valid pulses during busy are ignored.
REQ-029 Reset asserted on clk 30 of SHIFT_IN -> next edge all outputs at reset values, global_csb=1; a fresh command then completes normally.
REQ-030 CLK_DIV=1, back-to-back commands with rsp_ready=1 -> gpio_clk period 2 clk; second command accepted the clk after the first response handshake.

Source files
------------

// File: rtl/gpio_scan_master.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_scan_master
//  Description : Serial scan master for a GPIO-attached SRAM test chip.
//                Accepts one command, shifts the packet
//                {csb, web, addr, wdata} MSB first into the chip on gpio_in,
//                strobes gpio_sram_load, then for reads shifts DATA_WIDTH bits
//                back on gpio_out and reports the data plus a compare flag.
//
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                cmd_*                  - command handshake and fields
//                rsp_*                  - response handshake, data, mismatch
//                gpio_clk/scan/in/sram_load, global_csb - outputs to the chip
//                gpio_out               - serial data returned by the chip
//
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_scan_master #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_DIV     = 2,
    parameter int LOAD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_csb,
    input  logic                  cmd_web,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] cmd_expect,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_mismatch,
    output logic                  gpio_clk,
    output logic                  gpio_scan,
    output logic                  gpio_in,
    output logic                  gpio_sram_load,
    output logic                  global_csb,
    input  logic                  gpio_out
);

    localparam int PKT_WIDTH = ADDR_WIDTH + DATA_WIDTH + 2;

    // Bit counter spans the longest of the three scan sequences.
    localparam int c_MAX_A   = (PKT_WIDTH > DATA_WIDTH) ? PKT_WIDTH : DATA_WIDTH;
    localparam int c_MAX_CNT = (c_MAX_A > LOAD_CYCLES) ? c_MAX_A : LOAD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_PKT_LAST  = c_CNT_W'(PKT_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(LOAD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_SHIFT_IN  = 3'd1;
    localparam logic [2:0] c_S_LOAD      = 3'd2;
    localparam logic [2:0] c_S_SHIFT_OUT = 3'd3;
    localparam logic [2:0] c_S_RESP      = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_DIV_W-1:0]    r_div;
    logic                  r_phase;       // 0 = gpio_clk low half, 1 = high half
    logic [c_CNT_W-1:0]    r_cnt;
    logic [PKT_WIDTH-1:0]  r_shift;
    logic                  r_web;
    logic [DATA_WIDTH-1:0] r_expect;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_busy;
    logic w_half_end;
    logic w_tick;
    logic w_sample;

    assign w_busy     = (r_state == c_S_SHIFT_IN) || (r_state == c_S_LOAD) ||
                        (r_state == c_S_SHIFT_OUT);
    assign w_half_end = (r_div == c_DIV_LAST);
    // End of a whole scan cycle: last clk of the high half. State changes here,
    // so every state-derived output moves on the first clk of a low half.
    assign w_tick     = w_busy && r_phase && w_half_end;
    // Chip data is stable through the low half; take it on its last clk.
    assign w_sample   = (r_state == c_S_SHIFT_OUT) && !r_phase && w_half_end;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (cmd_valid) w_next_state = c_S_SHIFT_IN;
            end
            c_S_SHIFT_IN: begin
                if (w_tick && (r_cnt == c_PKT_LAST)) w_next_state = c_S_LOAD;
            end
            c_S_LOAD: begin
                if (w_tick && (r_cnt == c_LOAD_LAST))
                    w_next_state = r_web ? c_S_SHIFT_OUT : c_S_RESP;
            end
            c_S_SHIFT_OUT: begin
                if (w_tick && (r_cnt == c_DATA_LAST)) w_next_state = c_S_RESP;
            end
            c_S_RESP: begin
                if (rsp_ready) w_next_state = c_S_IDLE;
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        gpio_scan      = 1'b0;
        gpio_in        = 1'b0;
        gpio_sram_load = 1'b0;
        global_csb     = 1'b1;
        rsp_mismatch   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                cmd_ready = 1'b1;
            end
            c_S_SHIFT_IN: begin
                gpio_scan  = 1'b1;
                gpio_in    = r_shift[PKT_WIDTH-1];
                global_csb = 1'b0;
            end
            c_S_LOAD: begin
                gpio_sram_load = 1'b1;
                global_csb     = 1'b0;
            end
            c_S_SHIFT_OUT: begin
                gpio_scan  = 1'b1;
                global_csb = 1'b0;
            end
            c_S_RESP: begin
                rsp_valid    = 1'b1;
                rsp_mismatch = r_web && (r_rdata != r_expect);
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign gpio_clk  = r_phase;
    assign rsp_rdata = r_rdata;

    // ------------------------------------------------------------------------
    // Divider, bit counter and shift datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= '0;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_web    <= 1'b0;
            r_expect <= '0;
            r_rdata  <= '0;
        end else if (r_state == c_S_IDLE) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            if (cmd_valid) begin
                r_shift  <= {cmd_csb, cmd_web, cmd_addr, cmd_wdata};
                r_web    <= cmd_web;
                r_expect <= cmd_expect;
                r_rdata  <= '0;
            end
        end else if (w_busy) begin
            if (w_half_end) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_tick) begin
                // Restart the count whenever the scan sequence changes state.
                r_cnt <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
                if (r_state == c_S_SHIFT_IN) begin
                    r_shift <= {r_shift[PKT_WIDTH-2:0], 1'b0};
                end
            end
            if (w_sample) begin
                r_rdata <= {r_rdata[DATA_WIDTH-2:0], gpio_out};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_scan_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_scan_master
//  Description : Self-checking bench for gpio_scan_master. A timing model
//                derived from scan-cycle arithmetic predicts every output on
//                every cycle; a behavioural chip model decodes the serial
//                packet and serves reads. A second instance with CLK_DIV=1
//                runs back-to-back commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_scan_master;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int PW = AW + DW + 2;
    localparam int CD = 2;
    localparam int LC = 1;
    localparam int P  = 2 * CD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_csb = 1'b0, cmd_web = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0, cmd_expect = '0;
    logic          rsp_ready = 1'b0;
    logic          cmd_ready, rsp_valid, rsp_mismatch;
    logic [DW-1:0] rsp_rdata;
    logic          gpio_clk, gpio_scan, gpio_in, gpio_sram_load, global_csb, gpio_out;

    gpio_scan_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(CD), .LOAD_CYCLES(LC)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_csb(cmd_csb), .cmd_web(cmd_web), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_expect(cmd_expect), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_mismatch(rsp_mismatch), .gpio_clk(gpio_clk),
        .gpio_scan(gpio_scan), .gpio_in(gpio_in), .gpio_sram_load(gpio_sram_load),
        .global_csb(global_csb), .gpio_out(gpio_out)
    );

    // Second instance: CLK_DIV=1, write-only back-to-back traffic.
    logic          u1_cmd_valid = 1'b0;
    logic          u1_rsp_ready = 1'b0;
    logic          u1_gpio_out = 1'b0;
    logic          u1_cmd_ready, u1_rsp_valid, u1_rsp_mismatch;
    logic [DW-1:0] u1_rsp_rdata;
    logic          u1_gpio_clk, u1_gpio_scan, u1_gpio_in, u1_gpio_sram_load, u1_global_csb;

    gpio_scan_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(1), .LOAD_CYCLES(LC)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(u1_cmd_valid), .cmd_ready(u1_cmd_ready),
        .cmd_csb(1'b0), .cmd_web(1'b0), .cmd_addr(8'h12), .cmd_wdata(8'h34),
        .cmd_expect(8'h00), .rsp_valid(u1_rsp_valid), .rsp_ready(u1_rsp_ready),
        .rsp_rdata(u1_rsp_rdata), .rsp_mismatch(u1_rsp_mismatch), .gpio_clk(u1_gpio_clk),
        .gpio_scan(u1_gpio_scan), .gpio_in(u1_gpio_in), .gpio_sram_load(u1_gpio_sram_load),
        .global_csb(u1_global_csb), .gpio_out(u1_gpio_out)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Chip model: shifts gpio_in on rising gpio_clk while scanning, executes
    // the packet on the load strobe, and shifts read data out MSB first.
    // ------------------------------------------------------------------------
    logic [PW-1:0] chip_sr = '0;
    logic [DW-1:0] chip_out_sr = '0;
    logic [PW-1:0] last_pkt = '0;
    logic [DW-1:0] chip_mem [256];

    always @(posedge gpio_clk) begin
        if (gpio_sram_load) begin
            last_pkt <= chip_sr;
            if (!chip_sr[PW-1]) begin
                if (!chip_sr[PW-2]) chip_mem[chip_sr[PW-3:DW]] <= chip_sr[DW-1:0];
                else                chip_out_sr <= chip_mem[chip_sr[PW-3:DW]];
            end
        end else if (gpio_scan) begin
            chip_sr     <= {chip_sr[PW-2:0], gpio_in};
            chip_out_sr <= {chip_out_sr[DW-2:0], 1'b0};
        end
    end
    assign gpio_out = chip_out_sr[DW-1];

    // ------------------------------------------------------------------------
    // Cycle model: 0 idle, 1 scanning (m_k = clk index since accept), 2 resp.
    // ------------------------------------------------------------------------
    int            m_phase = 0;
    bit            m_after_rst = 1'b1;
    int            m_k = 0, m_total = 0;
    logic [PW-1:0] m_pkt = '0;
    logic          m_web = 1'b0, m_csb = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_expect = '0;
    logic [DW-1:0] exp_mem [256];

    logic [6:0]    e_ctl;
    logic [DW-1:0] e_rd;
    logic          e_mm, e_chk_data;
    int            s_idx, pos;

    always @(negedge clk) begin
        e_ctl = 7'b1000001;   // {ready, valid, gclk, scan, in, load, global_csb}
        e_rd = '0; e_mm = 1'b0; e_chk_data = 1'b0;
        if (m_phase == 0) begin
            e_chk_data = m_after_rst;
        end else if (m_phase == 1) begin
            s_idx = (m_k - 1) / P;
            pos   = (m_k - 1) % P;
            e_ctl = 7'b0;
            e_ctl[4] = (pos >= CD);
            if (s_idx < PW) begin
                e_ctl[3] = 1'b1;
                e_ctl[2] = m_pkt[PW-1-s_idx];
            end else if (s_idx < PW + LC) begin
                e_ctl[1] = 1'b1;
            end else begin
                e_ctl[3] = 1'b1;
            end
        end else begin
            e_ctl = 7'b0100001;
            e_chk_data = 1'b1;
            e_rd = m_web ? exp_mem[m_addr] : '0;
            e_mm = m_web && (e_rd != m_expect);
        end
        check("ctl{rdy,vld,gclk,scan,in,load,gcsb}",
              {cmd_ready, rsp_valid, gpio_clk, gpio_scan, gpio_in, gpio_sram_load, global_csb},
              e_ctl);
        if (e_chk_data) check("rsp{mismatch,rdata}", {rsp_mismatch, rsp_rdata}, {e_mm, e_rd});

        if (reset) begin
            m_phase = 0;
            m_after_rst = 1'b1;
        end else if (m_phase == 0) begin
            if (cmd_valid) begin
                m_pkt = {cmd_csb, cmd_web, cmd_addr, cmd_wdata};
                m_csb = cmd_csb; m_web = cmd_web; m_addr = cmd_addr;
                m_wdata = cmd_wdata; m_expect = cmd_expect;
                m_k = 1;
                m_total = (PW + LC + (cmd_web ? DW : 0)) * P;
                m_phase = 1;
                m_after_rst = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (m_k == m_total) begin
                m_phase = 2;
                if (!m_csb && !m_web) exp_mem[m_addr] = m_wdata;
            end else begin
                m_k++;
            end
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    end

    // ------------------------------------------------------------------------
    // CLK_DIV=1 model: gpio_clk alternates each clk, write lasts 38 clk,
    // response the clk after, next accept the clk after the handshake.
    // ------------------------------------------------------------------------
    int u1_phase = 0, u1_k = 0, u1_acc_n = 0, u1_acc_first = 0, u1_acc_last = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (u1_phase == 0) begin
                check("u1_cmd_ready", u1_cmd_ready, 1);
                if (u1_cmd_valid) begin
                    if (u1_acc_n == 0) u1_acc_first = cyc;
                    u1_acc_last = cyc;
                    u1_acc_n++;
                    u1_phase = 1;
                    u1_k = 1;
                end
            end else if (u1_phase == 1) begin
                check("u1_gpio_clk", u1_gpio_clk, (u1_k % 2 == 0));
                check("u1_rsp_valid_busy", u1_rsp_valid, 0);
                if (u1_k == (PW + LC) * 2) u1_phase = 2;
                else u1_k++;
            end else begin
                check("u1_rsp_valid", u1_rsp_valid, 1);
                if (u1_rsp_ready) u1_phase = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    task automatic do_cmd(input logic csb, input logic web, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] expv, input int hold,
                          input bit pulse, input int exp_lat, input logic [7:0] exp_rd,
                          input logic exp_mm);
        int lat;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_csb = csb; cmd_web = web; cmd_addr = addr;
        cmd_wdata = wdata; cmd_expect = expv; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_csb = ~csb; cmd_web = ~web; cmd_addr = ~addr;
        cmd_wdata = ~wdata; cmd_expect = ~expv;
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            cmd_valid = pulse && (lat % 7 == 3);
            @(posedge clk); #1;
            lat++;
        end
        cmd_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("rdata", rsp_rdata, exp_rd);
        check("mismatch", rsp_mismatch, exp_mm);
        repeat (hold) @(posedge clk);
        #1;
        check("rdata_held", rsp_rdata, exp_rd);
        check("cmd_ready_held", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            chip_mem[i] = '0;
            exp_mem[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Write 0x5A <- 0xC3, then read it back matching.
        do_cmd(1'b0, 1'b0, 8'h5A, 8'hC3, 8'h00, 0, 1'b0, 77, 8'h00, 1'b0);
        check("pkt_5A_C3", last_pkt, 18'b00_01011010_11000011);
        do_cmd(1'b0, 1'b1, 8'h5A, 8'h00, 8'hC3, 0, 1'b0, 109, 8'hC3, 1'b0);

        // Chip now holds 0xC2; expecting 0xC3 must flag a mismatch.
        do_cmd(1'b0, 1'b0, 8'h5A, 8'hC2, 8'h00, 3, 1'b1, 77, 8'h00, 1'b0);
        do_cmd(1'b0, 1'b1, 8'h5A, 8'h00, 8'hC3, 10, 1'b1, 109, 8'hC2, 1'b1);

        // Deselected write leaves memory untouched.
        do_cmd(1'b1, 1'b0, 8'h5A, 8'hFF, 8'h00, 0, 1'b0, 77, 8'h00, 1'b0);
        check("pkt_csb1", last_pkt, 18'b10_01011010_11111111);
        do_cmd(1'b0, 1'b1, 8'h5A, 8'h00, 8'hC2, 0, 1'b0, 109, 8'hC2, 1'b0);

        do_cmd(1'b0, 1'b0, 8'h33, 8'hA5, 8'h00, 1, 1'b0, 77, 8'h00, 1'b0);
        do_cmd(1'b0, 1'b1, 8'h33, 8'h00, 8'hA5, 2, 1'b0, 109, 8'hA5, 1'b0);

        // Reset on clk 30 of SHIFT_IN aborts the write.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_csb = 1'b0; cmd_web = 1'b0; cmd_addr = 8'h77; cmd_wdata = 8'h11;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_outputs{rdy,vld,gclk,scan,in,load,gcsb}",
              {cmd_ready, rsp_valid, gpio_clk, gpio_scan, gpio_in, gpio_sram_load, global_csb},
              7'b1000001);
        check("rst_rsp", {rsp_mismatch, rsp_rdata}, 9'h000);
        do_cmd(1'b0, 1'b1, 8'h77, 8'h00, 8'h00, 0, 1'b0, 109, 8'h00, 1'b0);
        do_cmd(1'b0, 1'b0, 8'h77, 8'h5E, 8'h00, 0, 1'b0, 77, 8'h00, 1'b0);
        do_cmd(1'b0, 1'b1, 8'h77, 8'h00, 8'h5E, 0, 1'b0, 109, 8'h5E, 1'b0);

        // Back-to-back on the CLK_DIV=1 instance.
        @(posedge clk); #1;
        u1_cmd_valid = 1'b1;
        u1_rsp_ready = 1'b1;
        for (int t = 0; t < 400 && u1_acc_n < 3; t++) @(posedge clk);
        #1 u1_cmd_valid = 1'b0;
        check("u1_accepts", u1_acc_n, 3);
        check("u1_accept_spacing", u1_acc_last - u1_acc_first, 80);
        for (int t = 0; t < 100 && u1_phase != 0; t++) @(posedge clk);
        #1 u1_rsp_ready = 1'b0;
        check("u1_idle_at_end", u1_phase, 0);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
